// File: rtl/src3_cpld_ifc_bridge.sv
// ============================================================================
//  Module   : src3_cpld_ifc_bridge
//  Function : IFC-bus glue: register file, power/reset FSM, 6-word block buffer
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module src3_cpld_ifc_bridge #(
  parameter int BSN       = 4,
  parameter int BRN       = 4,
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int BYTES_N   = 10
) (
  input  logic        clock_50MHz,
  input  logic        rst_n,
  input  logic        ifc_cs,
  input  logic        ifc_we_b,
  input  logic        ifc_oe_b,
  input  logic        ifc_avd,
  input  logic [7:0]  ifc_addr,
  inout  wire  [15:0] ifc_ad,
  input  logic [1:0]  pcb_ver,
  input  logic        voltage_drop,
  input  logic [15:0] io_in,
  input  logic        uart_rx,
  output logic        irq,
  output logic        status_led,
  output logic        error_led,
  output logic [15:0] io_out,
  output logic        uart_tx
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'b000,
    ST_PWR_ON      = 3'b001,
    ST_SYSTEM_UP   = 3'b010,
    ST_SWR_ASSERT  = 3'b100,
    ST_READ_BLOCK  = 3'b101,
    ST_WRITE_BLOCK = 3'b110
  } state_t;

  function automatic logic [15:0] rev16(input logic [15:0] v);
    for (int i = 0; i < 16; i++) rev16[i] = v[15-i];
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  logic        w_unused_ok;
  assign w_unused_ok = ^{ifc_avd, uart_rx, BSN, BRN, CLK_FRE, BAUD_RATE, BYTES_N};

  logic [7:0]  w_addr;
  assign w_addr = rev8(ifc_addr);

  // Write strobe edge captures the access; the toggle hands it to the core clock.
  logic [7:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_wr_tog;
  always_ff @(posedge ifc_we_b or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_tog  <= 1'b0;
    end else if (!ifc_cs) begin
      r_wr_addr <= w_addr;
      r_wr_data <= rev16(ifc_ad);
      r_wr_tog  <= ~r_wr_tog;
    end
  end

  logic r_tog_s1, r_tog_s2, r_tog_s3;
  logic r_oe_s1, r_oe_s2, r_oe_s3;
  logic r_cs_s1, r_cs_s2;
  logic r_vd_s1, r_vd_s2;
  always_ff @(posedge clock_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      {r_tog_s1, r_tog_s2, r_tog_s3} <= 3'b000;
      {r_oe_s1, r_oe_s2, r_oe_s3}    <= 3'b111;
      {r_cs_s1, r_cs_s2}             <= 2'b11;
      {r_vd_s1, r_vd_s2}             <= 2'b00;
    end else begin
      {r_tog_s1, r_tog_s2, r_tog_s3} <= {r_wr_tog, r_tog_s1, r_tog_s2};
      {r_oe_s1, r_oe_s2, r_oe_s3}    <= {ifc_oe_b, r_oe_s1, r_oe_s2};
      {r_cs_s1, r_cs_s2}             <= {ifc_cs, r_cs_s1};
      {r_vd_s1, r_vd_s2}             <= {voltage_drop, r_vd_s1};
    end
  end

  logic w_wr_stb, w_oe_rise;
  assign w_wr_stb  = r_tog_s2 ^ r_tog_s3;
  assign w_oe_rise = r_oe_s2 & ~r_oe_s3;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_pwr_cnt;
  logic        r_pf_flag, r_write_ok, r_status_led, r_error_led;
  logic        r_rd_data_pend, r_rd_stat_pend;
  logic [15:0] r_io_out, r_checksum, r_length;
  logic [7:0]  r_hs_hi;
  logic [2:0]  r_hs_cmd, r_pi;
  logic [15:0] r_buf [0:5];

  logic [2:0]  w_n;
  logic [15:0] w_xor;
  logic        w_in_block;
  always_comb begin
    w_n   = (r_length[15:1] >= 15'd6) ? 3'd6 : r_length[3:1];
    w_xor = '0;
    for (int i = 0; i < 6; i++)
      if (3'(i) < w_n) w_xor = w_xor ^ r_buf[i];
  end
  assign w_in_block = (r_state == ST_READ_BLOCK) || (r_state == ST_WRITE_BLOCK);

  logic [15:0] w_rdata;
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      8'h10: w_rdata = {10'd0, pcb_ver, r_pf_flag, r_state};
      8'h20: w_rdata = r_io_out;
      8'h22: w_rdata = io_in;
      8'h40: w_rdata = {r_hs_hi, 3'd0, r_write_ok, w_in_block, r_hs_cmd};
      8'h50: w_rdata = (r_state == ST_READ_BLOCK) ? w_xor : r_checksum;
      8'h52: w_rdata = r_length;
      8'h54: w_rdata = (w_in_block && r_pi < 3'd6) ? r_buf[r_pi] : 16'd0;
      default: w_rdata = '0;
    endcase
  end

  assign ifc_ad = (!ifc_cs && !ifc_oe_b) ? rev16(w_rdata) : 16'bz;

  logic       w_hs_wr;
  logic [2:0] w_cmd;
  assign w_hs_wr = w_wr_stb && (r_wr_addr == 8'h40);
  assign w_cmd   = r_wr_data[2:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       w_state_nxt = ST_PWR_ON;
      ST_PWR_ON:     if (r_pwr_cnt == 4'd15) w_state_nxt = ST_SYSTEM_UP;
      ST_SYSTEM_UP: begin
        if (w_hs_wr && w_cmd == 3'b011)      w_state_nxt = ST_READ_BLOCK;
        else if (w_hs_wr && w_cmd == 3'b101) w_state_nxt = ST_WRITE_BLOCK;
      end
      ST_READ_BLOCK, ST_WRITE_BLOCK:
        if (w_hs_wr && w_cmd == 3'b000) w_state_nxt = ST_SYSTEM_UP;
      ST_SWR_ASSERT: if (!r_vd_s2) w_state_nxt = ST_SYSTEM_UP;
      default:       w_state_nxt = ST_IDLE;
    endcase
    if (r_vd_s2 && r_state != ST_IDLE) w_state_nxt = ST_SWR_ASSERT;
  end

  always_ff @(posedge clock_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_pwr_cnt      <= '0;
      r_pf_flag      <= 1'b0;
      r_write_ok     <= 1'b0;
      r_status_led   <= 1'b0;
      r_error_led    <= 1'b0;
      r_rd_data_pend <= 1'b0;
      r_rd_stat_pend <= 1'b0;
      r_io_out       <= '0;
      r_checksum     <= '0;
      r_length       <= 16'd12;
      r_hs_hi        <= '0;
      r_hs_cmd       <= '0;
      r_pi           <= '0;
      for (int i = 0; i < 6; i++) r_buf[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_status_led <= (w_state_nxt == ST_SYSTEM_UP) || (w_state_nxt == ST_READ_BLOCK) ||
                      (w_state_nxt == ST_WRITE_BLOCK);
      r_error_led  <= (w_state_nxt == ST_SWR_ASSERT);
      if (r_state == ST_PWR_ON) r_pwr_cnt <= r_pwr_cnt + 4'd1;

      if (w_wr_stb) begin
        case (r_wr_addr)
          8'h20: r_io_out   <= r_wr_data;
          8'h40: begin
            r_hs_hi  <= r_wr_data[15:8];
            r_hs_cmd <= r_wr_data[2:0];
          end
          8'h50: r_checksum <= r_wr_data;
          8'h52: r_length   <= r_wr_data;
          8'h54: if (r_state == ST_WRITE_BLOCK && r_pi < 3'd6) begin
            r_buf[r_pi] <= r_wr_data;
            r_pi        <= r_pi + 3'd1;
          end
          default: ;
        endcase
      end

      // Read side effects fire once the host releases output enable.
      if (!r_oe_s2 && !r_cs_s2) begin
        r_rd_data_pend <= (w_addr == 8'h54);
        r_rd_stat_pend <= (w_addr == 8'h10);
      end else if (w_oe_rise) begin
        r_rd_data_pend <= 1'b0;
        r_rd_stat_pend <= 1'b0;
      end
      if (w_oe_rise && r_rd_data_pend && r_state == ST_READ_BLOCK && r_pi < 3'd6)
        r_pi <= r_pi + 3'd1;

      if (r_vd_s2 && r_state != ST_IDLE)   r_pf_flag <= 1'b1;
      else if (w_oe_rise && r_rd_stat_pend) r_pf_flag <= 1'b0;

      if (r_state != ST_WRITE_BLOCK && w_state_nxt == ST_WRITE_BLOCK)
        r_write_ok <= 1'b0;
      else if (r_state == ST_WRITE_BLOCK && r_pi == w_n && w_xor == r_checksum)
        r_write_ok <= 1'b1;

      if (r_state != w_state_nxt &&
          (w_state_nxt == ST_READ_BLOCK || w_state_nxt == ST_WRITE_BLOCK))
        r_pi <= '0;
    end
  end

  assign irq        = r_pf_flag;
  assign status_led = r_status_led;
  assign error_led  = r_error_led;
  assign io_out     = r_io_out;
  assign uart_tx    = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_src3_cpld_ifc_bridge.sv
// ============================================================================
//  Module   : tb_src3_cpld_ifc_bridge
//  Function : Directed bus-level bench for src3_cpld_ifc_bridge
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_src3_cpld_ifc_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifc_cs = 1'b1, ifc_we_b = 1'b1, ifc_oe_b = 1'b1, ifc_avd = 1'b0;
  logic [7:0]  ifc_addr = '0;
  logic [15:0] r_drv = '0;
  logic        r_drv_en = 1'b0;
  wire  [15:0] ifc_ad;
  logic [1:0]  pcb_ver = 2'b10;
  logic        voltage_drop = 1'b0;
  logic [15:0] io_in = 16'hC3A5;
  logic        uart_rx = 1'b1;
  logic        irq, status_led, error_led, uart_tx;
  logic [15:0] io_out;

  int n_vec = 0;
  int n_bad = 0;

  assign ifc_ad = r_drv_en ? r_drv : 16'bz;

  always #10 clk = ~clk;

  src3_cpld_ifc_bridge dut (
    .clock_50MHz (clk),
    .rst_n       (rst_n),
    .ifc_cs      (ifc_cs),
    .ifc_we_b    (ifc_we_b),
    .ifc_oe_b    (ifc_oe_b),
    .ifc_avd     (ifc_avd),
    .ifc_addr    (ifc_addr),
    .ifc_ad      (ifc_ad),
    .pcb_ver     (pcb_ver),
    .voltage_drop(voltage_drop),
    .io_in       (io_in),
    .uart_rx     (uart_rx),
    .irq         (irq),
    .status_led  (status_led),
    .error_led   (error_led),
    .io_out      (io_out),
    .uart_tx     (uart_tx)
  );

  function automatic logic [15:0] rev16(input logic [15:0] v);
    for (int i = 0; i < 16; i++) rev16[i] = v[15-i];
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    ifc_addr = rev8(a);
    r_drv    = rev16(d);
    r_drv_en = 1'b1;
    ifc_cs   = 1'b0;
    #5  ifc_we_b = 1'b0;
    #17 ifc_we_b = 1'b1;
    #5  ifc_cs   = 1'b1;
    r_drv_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [15:0] d, output logic [15:0] raw);
    @(negedge clk);
    ifc_addr = rev8(a);
    ifc_cs   = 1'b0;
    ifc_oe_b = 1'b0;
    repeat (5) @(negedge clk);
    raw = ifc_ad;
    d   = rev16(raw);
    ifc_oe_b = 1'b1;
    @(negedge clk);
    ifc_cs = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] d, raw;
    bus_rd(a, d, raw);
    chk(tag, d, exp);
  endtask

  logic [15:0] blk [0:5];
  logic [15:0] d, raw;
  logic        saw_err;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blk[0] = 16'h0112; blk[1] = 16'h3344; blk[2] = 16'h5566;
    blk[3] = 16'h0223; blk[4] = 16'h7788; blk[5] = 16'h99aa;

    repeat (3) @(negedge clk);
    chk("rst_leds_irq", {13'd0, irq, status_led, error_led}, 16'd0);
    chk("rst_io_out", io_out, 16'h0000);
    chk("rst_uart_tx", {15'd0, uart_tx}, 16'd1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    rd_chk("status_up", 8'h10, 16'h0022);
    chk("status_led_up", {15'd0, status_led}, 16'd1);
    rd_chk("length_rst", 8'h52, 16'h000C);
    rd_chk("io_in", 8'h22, 16'hC3A5);
    rd_chk("unmapped", 8'h30, 16'h0000);
    rd_chk("data_outside", 8'h54, 16'h0000);

    // good block write
    bus_wr(8'h40, 16'h0105);
    rd_chk("hs_wb", 8'h40, 16'h010D);
    rd_chk("status_wb", 8'h10, 16'h0026);
    bus_wr(8'h50, 16'h8B31);
    bus_wr(8'h52, 16'd12);
    for (int i = 0; i < 6; i++) bus_wr(8'h54, blk[i]);
    rd_chk("hs_write_ok", 8'h40, 16'h011D);
    bus_wr(8'h40, 16'h0100);
    rd_chk("status_back_up", 8'h10, 16'h0022);

    // bad checksum
    bus_wr(8'h40, 16'h0105);
    bus_wr(8'h50, 16'h8B30);
    bus_wr(8'h52, 16'd12);
    for (int i = 0; i < 6; i++) bus_wr(8'h54, blk[i]);
    rd_chk("hs_bad_cksum", 8'h40, 16'h010D);
    bus_wr(8'h40, 16'h0100);

    // unsupported command stores without transition
    bus_wr(8'h40, 16'h0107);
    rd_chk("hs_bad_cmd", 8'h40, 16'h0107);
    rd_chk("status_bad_cmd", 8'h10, 16'h0022);

    // block read
    bus_wr(8'h40, 16'h0103);
    rd_chk("hs_rb", 8'h40, 16'h010B);
    rd_chk("length_rb", 8'h52, 16'h000C);
    rd_chk("rd0", 8'h54, 16'h0112);
    rd_chk("rd1", 8'h54, 16'h3344);
    rd_chk("rd2", 8'h54, 16'h5566);
    rd_chk("rd3", 8'h54, 16'h0223);
    rd_chk("rd4", 8'h54, 16'h7788);
    rd_chk("rd5", 8'h54, 16'h99aa);
    rd_chk("cksum_rb", 8'h50, 16'h8B31);
    rd_chk("rd6_sat", 8'h54, 16'h0000);
    rd_chk("status_rb", 8'h10, 16'h0025);
    bus_wr(8'h40, 16'h0100);

    // short length: N = 2
    bus_wr(8'h40, 16'h0005);
    bus_wr(8'h52, 16'd4);
    bus_wr(8'h50, 16'h3256);
    bus_wr(8'h54, 16'h0112);
    rd_chk("hs_short_pend", 8'h40, 16'h0008 | 16'h0005);
    bus_wr(8'h54, 16'h3344);
    rd_chk("hs_short_ok", 8'h40, 16'h001D);
    bus_wr(8'h40, 16'h0000);
    bus_wr(8'h52, 16'd12);

    // 40 ns power-fail pulse
    chk("irq_before_pf", {15'd0, irq}, 16'd0);
    @(negedge clk);
    voltage_drop = 1'b1;
    #40 voltage_drop = 1'b0;
    saw_err = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (error_led) saw_err = 1'b1;
    end
    chk("pf_error_led", {15'd0, saw_err}, 16'd1);
    chk("pf_irq", {15'd0, irq}, 16'd1);
    rd_chk("status_pf", 8'h10, 16'h002A);
    chk("irq_cleared", {15'd0, irq}, 16'd0);
    rd_chk("status_pf_clr", 8'h10, 16'h0022);

    // sustained power fail
    @(negedge clk);
    voltage_drop = 1'b1;
    repeat (6) @(negedge clk);
    chk("swr_leds", {14'd0, status_led, error_led}, 16'b01);
    rd_chk("status_swr", 8'h10, 16'h002C);
    voltage_drop = 1'b0;
    repeat (6) @(negedge clk);
    rd_chk("status_after_swr", 8'h10, 16'h002A);
    rd_chk("status_swr_clr", 8'h10, 16'h0022);

    // io_out and bus bit order
    bus_wr(8'h20, 16'h5A5A);
    chk("io_out_5a5a", io_out, 16'h5A5A);
    bus_rd(8'h20, d, raw);
    chk("bus_raw_5a5a", raw, 16'h5A5A);
    bus_wr(8'h20, 16'h1234);
    chk("io_out_1234", io_out, 16'h1234);
    bus_rd(8'h20, d, raw);
    chk("bus_raw_1234", raw, 16'h2C48);
    chk("bus_word_1234", d, 16'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/src3_cpld_ifc_bridge.md
Name: src3_cpld_ifc_bridge

Overview:
- CPLD glue block between the host IFC bus (16-bit multiplexed AD, externally latched 8-bit address) and board I/O.
- Provides a small register file, a power/reset state machine, and a 6-word block buffer.
- The host moves data blocks through the buffer using a handshake register, a length register and an XOR checksum.
- The UART pins are present but reserved in this revision.

Parameters:
- st_idle, 3'b000, idle state encoding
- st_pwr_on, 3'b001, power-on state encoding
- st_system_up, 3'b010, normal-operation state encoding
- st_swr_assert, 3'b100, power-fail / soft-reset state encoding
- st_read_block, 3'b101, host block-read state encoding
- st_write_block, 3'b110, host block-write state encoding
- BSN, 4, UART stop/shift setting; reserved, no effect
- BRN, 4, UART receive setting; reserved, no effect
- CLK_FRE, 50, core clock in MHz
- BAUD_RATE, 115200, UART rate; reserved, no effect
- bytes_n, 10, UART frame bytes; reserved, no effect

Ports:
- clock_50MHz, in, 1: core clock
- rst_n, in, 1: asynchronous active-low reset
- ifc_cs, in, 1: chip select, active low
- ifc_we_b, in, 1: write strobe, active low
- ifc_oe_b, in, 1: output enable, active low
- ifc_avd, in, 1: address valid (informational only)
- ifc_addr, in, 8: latched address, bit-reversed
- ifc_ad, inout, 16: data bus, bit-reversed
- pcb_ver, in, 2: board revision
- voltage_drop, in, 1: AC-fail detect, active high
- io_in, in, 16: general inputs
- uart_rx, in, 1: reserved
- irq, out, 1: interrupt to host
- status_led, out, 1: status indicator
- error_led, out, 1: error indicator
- io_out, out, 16: general outputs
- uart_tx, out, 1: constant 1

Behaviour:
- Bit order:
  - internal address A = {ifc_addr[0],…,ifc_addr[7]}.
  - internal word W = {ifc_ad[0],…,ifc_ad[15]}, i.e. IFC bit 0 is the MSB.
  - Read data is reversed the same way.
- Reads:
  - ifc_ad is driven combinationally with reverse(reg[A]) while ifc_cs=0 and ifc_oe_b=0; otherwise high-Z.
  - Unmapped addresses read 0.
- Writes:
  - On posedge ifc_we_b with ifc_cs=0, A and W are captured into a shadow register and a toggle flag flips.
  - The toggle is 2-flop synchronized to clock_50MHz; the write is applied 2-3 cycles later.
  - A 17 ns write pulse must be captured.
- Register map:
  - 0x10 STATUS (R): [2:0]=state, [3]=pf_flag, [5:4]=pcb_ver, others 0.
  - 0x20 IO_OUT (RW), reset 0; drives io_out.
  - 0x22 IO_IN (R): io_in.
  - 0x40 HANDSHAKE (RW):
    - bits [15:8] and [2:0] are stored; reset 0.
    - [3] READY (R) = 1 in read_block/write_block.
    - [4] WRITE_OK (R).
  - 0x50 CHECKSUM:
    - write_block: host writes the expected value.
    - read_block: reads the XOR of buffer words 0..N-1.
  - 0x52 LENGTH (RW): in bytes; reset 12; N = min(LENGTH/2, 6).
  - 0x54 DATA (RW): data port at pointer pi.
- Block buffer and pointer:
  - 6x16 buffer, reset 0.
  - pi resets to 0 on entry to either block state.
  - DATA write in write_block: buffer[pi]=W, then pi++.
  - DATA read in read_block: returns buffer[pi]; pi++ one cycle after the synchronized ifc_oe_b rising edge.
  - pi saturates at 6; accesses at pi=6 write nothing and read 0.
  - DATA access outside block states has no effect and reads 0.
- WRITE_OK:
  - Set in write_block when pi==N and the XOR of buffer[0..N-1] equals CHECKSUM.
  - Cleared on entry to write_block.
- State machine:
  - reset → idle; idle→pwr_on next cycle; pwr_on→system_up after 16 cycles.
  - From system_up, a HANDSHAKE write with [2:0]=3'b011 → read_block; [2:0]=3'b101 → write_block.
  - In either block state, [2:0]=3'b000 → system_up.
  - Other command values store but do not transition.
- Power fail:
  - voltage_drop=1 (synchronized) in any non-idle state → swr_assert and pf_flag=1.
  - swr_assert→system_up when voltage_drop=0.
  - pf_flag clears on a STATUS read.
- Outputs:
  - irq = pf_flag.
  - status_led = 1 in system_up/read_block/write_block.
  - error_led = 1 in swr_assert.
  - All outputs are 0 during reset, except uart_tx=1 and ifc_ad=Z.

Test Plan:
- Release rst_n, wait 20 cycles, read 0x10 with pcb_ver=2'b10 → 0x0022 (state 010, pcb_ver in [5:4]).
- Write 0x0105 to 0x40, read 0x40 → bit3=1, state 110. Write CHECKSUM=0x0112^0x3344^0x5566^0x0223^0x7788^0x99aa, LENGTH=12, then 6 DATA words 0x0112…0x99aa. Read 0x40 → bit4=1. Write 0x0100 → state 010.
- Same sequence with one bad CHECKSUM → bit4=0.
- Write 0x0103 to 0x40; read 0x52 → 12; six DATA reads return 0x0112,0x3344,…,0x99aa; read 0x50 matches their XOR; a seventh read → 0.
- Pulse voltage_drop high 40 ns → irq=1, error_led=1, state 100. After deassert, state 010; STATUS read shows bit3=1, after which irq=0.
- Write 0x5A5A to 0x20 → io_out=0x5A5A. Verify the bit-reversed bus value on ifc_ad during the read-back.
